divider_seq: RTL
================

// Module: divider_seq
// PURPOSE
//   Iterative unsigned restoring divider; the inverse operation of the team's 4-bit combinational multiplier.
//   Divides dividend A by divisor B and returns quotient Q and remainder R.
//   Produces one quotient bit per clock and uses a start/busy/done handshake.
//   Sits beside the multiplier in the arithmetic datapath; also used to check M = A*B by division.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (A, B, Q, R); legal range 2..16
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active-low
//   start        in   1      request; sampled only in IDLE
//   A            in   WIDTH  dividend (unsigned); captured on the accepting edge
//   B            in   WIDTH  divisor (unsigned); captured on the accepting edge
//   Q            out  WIDTH  quotient; registered
//   R            out  WIDTH  remainder; registered
//   busy         out  1      high while a division is in progress (RUN state)
//   done         out  1      one-cycle pulse when Q/R/div_by_zero become valid
//   div_by_zero  out  1      high with done when captured B==0; holds until next accept
// BEHAVIOUR
//   Reset
//     - rst_n low at a rising edge: state=IDLE; Q, R, busy, done, div_by_zero = 0; internal regs = 0.
//     - Reset wins over every other event, including mid-RUN; a division in progress is abandoned, no done.
//   FSM states: IDLE, RUN, DONE
//     - IDLE, start=1, B!=0: latch A into quotient shift reg and B into divisor reg;
//       partial remainder=0; count=WIDTH; busy=1; -> RUN.
//     - IDLE, start=1, B==0: -> DONE; Q=all ones, R=A, div_by_zero=1; RUN is skipped.
//     - IDLE, start=0: hold; Q/R/div_by_zero keep last values.
//     - RUN: each edge runs one restoring step:
//         t = {rem[WIDTH-1:0], quo[WIDTH-1]} (WIDTH+1 bits); quo <<= 1;
//         if t >= {1'b0,div}: rem=t-div, quo[0]=1; else rem=t[WIDTH-1:0], quo[0]=0.
//       count decrements; the step with count==1 writes final Q=quo, R=rem; busy=0; -> DONE.
//     - DONE: done=1 for exactly this one cycle; -> IDLE unconditionally.
//   Latency
//     - Accept edge E: done=1 during the cycle after edge E+WIDTH (WIDTH RUN cycles).
//     - B==0: done=1 during the cycle after edge E+1.
//     - Back-to-back throughput: one division per WIDTH+2 cycles.
//   Handshake
//     - start ignored in RUN and DONE; no queueing.
//     - A/B may change freely after the accepting edge.
//   Width rules
//     - Partial remainder compare/subtract is WIDTH+1 bits; no overflow is possible.
//     - Q < 2^WIDTH always; R < B for B!=0.
//     - Invariant for B!=0: Q*B + R == A.
//   Outputs change only on clock edges. Q and R are undefined-free: they hold the last result
//   (or 0 after reset) in every state and update only at RUN->DONE or on the IDLE->DONE divide-by-zero path.
// TESTING (WIDTH=4)
//   - Reset, then A=10,B=10 start 1 cycle -> busy 4 cycles; done pulse at cycle 5; Q=1,R=0,div_by_zero=0.
//   - A=15,B=0 -> done 2 cycles after accept; Q=15,R=15,div_by_zero=1; no busy.
//   - Sequence 15/15, 11/13, 15/9, 9/3 -> (Q,R)=(1,0),(0,11),(1,6),(3,0).
//   - Hold start=1 continuously with A=15,B=1 -> Q=15,R=0; accepts exactly every 6 cycles;
//     changing A/B mid-RUN has no effect.
//   - Pulse rst_n low at the 2nd RUN cycle of 9/3 -> IDLE, all outputs 0, no done.
//     A fresh start then gives Q=3,R=0.
//   - Exhaustive sweep of all 256 (A,B) pairs -> B!=0: Q*B+R==A and R<B; B==0: div_by_zero=1,Q=15,R=A.

Source files
------------

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor bypasses the iteration and reports Q=all ones, R=A with div_by_zero.
module divider_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // S_ZERO spends one cycle so a zero divisor reports done two cycles after accept
  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] quo, rem, div;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] quo_step, rem_step;
  logic             busy_nxt, done_nxt;

  // One restoring step on the current partial remainder / quotient
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    fits     = (trial >= {1'b0, div});
    quo_step = {quo[WIDTH-2:0], fits};
    rem_step = fits ? (trial[WIDTH-1:0] - div) : trial[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (B == '0) ? S_ZERO : S_RUN;
      end
      S_ZERO:  state_nxt = S_DONE;
      S_RUN: begin
        if (count == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode, fed into the busy/done registers
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == S_RUN)  busy_nxt = 1'b1;
    if (state_nxt == S_DONE) done_nxt = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo         <= '0;
      rem         <= '0;
      div         <= '0;
      count       <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            quo         <= A;
            div         <= B;
            rem         <= '0;
            count       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
          end
        end
        S_ZERO: begin
          Q           <= '1;
          R           <= quo;
          div_by_zero <= 1'b1;
        end
        S_RUN: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            Q <= quo_step;
            R <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
